// File: rtl/id_decode_stage_if.sv
// Signal bundle around the decode stage: FE/ID inputs, writeback port, fetch controls
// and the ID/EX pipeline latch outputs.
interface id_decode_stage_if;
   logic [15:0] id_instr;
   logic [15:0] id_instr_addr;
   logic        wb_wr_en;
   logic [2:0]  wb_rd;
   logic [15:0] wb_data;
   logic        ex_branch_taken;
   logic        ex_stall;
   logic        PC_WR_EN;
   logic        FE_LATCH_WR;
   logic [1:0]  ctr_sig;
   logic [15:0] jump_target;
   logic        ex_valid;
   logic        ex_reg_wr;
   logic        ex_mem_rd;
   logic        ex_mem_wr;
   logic [3:0]  ex_op;
   logic [2:0]  ex_rd;
   logic [15:0] ex_a;
   logic [15:0] ex_b;
   logic [15:0] ex_imm;
   logic [15:0] ex_pc;
   logic        halted;

   modport slave (
      input  id_instr, id_instr_addr, wb_wr_en, wb_rd, wb_data, ex_branch_taken, ex_stall,
      output PC_WR_EN, FE_LATCH_WR, ctr_sig, jump_target,
      output ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_op, ex_rd,
      output ex_a, ex_b, ex_imm, ex_pc, halted
   );

   modport master (
      output id_instr, id_instr_addr, wb_wr_en, wb_rd, wb_data, ex_branch_taken, ex_stall,
      input  PC_WR_EN, FE_LATCH_WR, ctr_sig, jump_target,
      input  ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_op, ex_rd,
      input  ex_a, ex_b, ex_imm, ex_pc, halted
   );
endinterface

// File: rtl/id_decode_stage.sv
// Decode stage: register file, load-use interlock, JMP redirect, wrong-path squash and HALT,
// feeding the ID/EX latch and steering the fetch unit.
module id_decode_stage #(
   parameter int         FLUSH_SLOTS = 1,
   parameter logic [3:0] HALT_OP     = 4'hF
) (
   input logic              CLOCK_50,
   input logic              reset,
   id_decode_stage_if.slave bus
);

   typedef enum logic [1:0] {S_RUN, S_SQUASH, S_HALT} state_t;

   typedef struct packed {
      logic        valid;
      logic        reg_wr;
      logic        mem_rd;
      logic        mem_wr;
      logic [3:0]  op;
      logic [2:0]  rd;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] imm;
      logic [15:0] pc;
   } ex_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   ex_t         ex_q, ex_d, issue;
   logic [15:0] regs_q [8];
   logic [15:0] regs_d [8];

   logic [3:0]  op;
   logic [2:0]  rd_f, rs_f, rt_f;
   logic [15:0] rs_val, rt_val, rd_val;
   logic        is_alu, uses_rs, uses_rd, load_use;
   logic        pc_wr, fe_wr;
   logic [1:0]  ctr;

   function automatic logic [15:0] read_port(input logic [2:0]  idx,
                                             input logic        wen,
                                             input logic [2:0]  widx,
                                             input logic [15:0] wdata,
                                             input logic [15:0] stored);
      logic [15:0] val;
      val = stored;
      if (wen && (widx == idx)) val = wdata;
      if (idx == 3'd0) val = 16'd0;
      return val;
   endfunction

   assign op     = bus.id_instr[15:12];
   assign rd_f   = bus.id_instr[11:9];
   assign rs_f   = bus.id_instr[8:6];
   assign rt_f   = bus.id_instr[5:3];

   assign rs_val = read_port(rs_f, bus.wb_wr_en, bus.wb_rd, bus.wb_data, regs_q[rs_f]);
   assign rt_val = read_port(rt_f, bus.wb_wr_en, bus.wb_rd, bus.wb_data, regs_q[rt_f]);
   assign rd_val = read_port(rd_f, bus.wb_wr_en, bus.wb_rd, bus.wb_data, regs_q[rd_f]);

   assign is_alu  = (op >= 4'd1) && (op <= 4'd4);
   assign uses_rs = (op >= 4'd1) && (op <= 4'd8);
   assign uses_rd = (op == 4'd7) || (op == 4'd8);

   // A load still in EX cannot forward in time; stall if it targets any source we read.
   assign load_use = ex_q.valid && ex_q.mem_rd && (ex_q.rd != 3'd0) &&
                     ((uses_rs && (ex_q.rd == rs_f)) ||
                      (is_alu  && (ex_q.rd == rt_f)) ||
                      (uses_rd && (ex_q.rd == rd_f)));

   assign bus.jump_target = bus.id_instr_addr +
                            {{3{bus.id_instr[11]}}, bus.id_instr[11:0], 1'b0};

   always_comb begin
      issue        = '0;
      issue.valid  = 1'b1;
      issue.op     = (op <= 4'd8) ? op : 4'd0;
      issue.reg_wr = (op >= 4'd1) && (op <= 4'd6);
      issue.mem_rd = (op == 4'd6);
      issue.mem_wr = (op == 4'd7);
      issue.rd     = rd_f;
      issue.a      = rs_val;
      issue.b      = is_alu ? rt_val : rd_val;
      issue.imm    = {{10{bus.id_instr[5]}}, bus.id_instr[5:0]};
      issue.pc     = bus.id_instr_addr;
   end

   always_comb begin
      regs_d = regs_q;
      if (bus.wb_wr_en && (bus.wb_rd != 3'd0)) regs_d[bus.wb_rd] = bus.wb_data;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ex_d    = ex_q;
      pc_wr   = 1'b1;
      fe_wr   = 1'b1;
      ctr     = 2'd0;
      if (bus.ex_stall) begin
         pc_wr = 1'b0;
         fe_wr = 1'b0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (bus.ex_branch_taken) begin
                  ex_d = '0;
                  if (FLUSH_SLOTS > 1) begin
                     cnt_d   = 2'(FLUSH_SLOTS - 1);
                     state_d = S_SQUASH;
                  end
               end else if (load_use) begin
                  ex_d  = '0;
                  pc_wr = 1'b0;
                  fe_wr = 1'b0;
               end else if (op == 4'd9) begin
                  ex_d    = '0;
                  ctr     = 2'd2;
                  cnt_d   = 2'(FLUSH_SLOTS);
                  state_d = S_SQUASH;
               end else if (op == HALT_OP) begin
                  ex_d    = '0;
                  pc_wr   = 1'b0;
                  fe_wr   = 1'b0;
                  state_d = S_HALT;
               end else begin
                  ex_d = issue;
               end
            end
            S_SQUASH: begin
               ex_d = '0;
               // A new redirect restarts the count; this slot is already one of the flushed ones.
               if (bus.ex_branch_taken) begin
                  if (FLUSH_SLOTS > 1) cnt_d = 2'(FLUSH_SLOTS - 1);
                  else                 state_d = S_RUN;
               end else begin
                  cnt_d = cnt_q - 2'd1;
                  if (cnt_q == 2'd1) state_d = S_RUN;
               end
            end
            S_HALT: begin
               ex_d  = '0;
               pc_wr = 1'b0;
               fe_wr = 1'b0;
            end
            default: state_d = S_RUN;
         endcase
      end
      if (reset) begin
         pc_wr = 1'b1;
         fe_wr = 1'b1;
         ctr   = 2'd0;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= S_RUN;
         cnt_q   <= 2'd0;
         ex_q    <= '0;
         for (int i = 0; i < 8; i++) regs_q[i] <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ex_q    <= ex_d;
         regs_q  <= regs_d;
      end
   end

   assign bus.PC_WR_EN    = pc_wr;
   assign bus.FE_LATCH_WR = fe_wr;
   assign bus.ctr_sig     = ctr;
   assign bus.ex_valid    = ex_q.valid;
   assign bus.ex_reg_wr   = ex_q.reg_wr;
   assign bus.ex_mem_rd   = ex_q.mem_rd;
   assign bus.ex_mem_wr   = ex_q.mem_wr;
   assign bus.ex_op       = ex_q.op;
   assign bus.ex_rd       = ex_q.rd;
   assign bus.ex_a        = ex_q.a;
   assign bus.ex_b        = ex_q.b;
   assign bus.ex_imm      = ex_q.imm;
   assign bus.ex_pc       = ex_q.pc;
   assign bus.halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed and random stimulus for id_decode_stage, checked against a behavioural model
// of the decode rules (register array, remaining-squash count, halt flag).
module tb_id_decode_stage;
   localparam int         FS  = 2;
   localparam logic [3:0] HOP = 4'hF;

   typedef struct packed {
      logic        valid;
      logic        reg_wr;
      logic        mem_rd;
      logic        mem_wr;
      logic [3:0]  op;
      logic [2:0]  rd;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] imm;
      logic [15:0] pc;
   } mex_t;

   logic CLOCK_50 = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   logic [15:0] m_reg [8];
   int          m_squash, n_squash;
   bit          m_halt, n_halt;
   mex_t        m_ex, n_ex;
   logic        e_pcwr, e_felw;
   logic [1:0]  e_ctr;
   logic [15:0] e_jt;
   logic        obs_pcwr, obs_felw;
   logic [1:0]  obs_ctr;
   logic [15:0] obs_jt;

   id_decode_stage_if bus ();

   id_decode_stage #(.FLUSH_SLOTS(FS), .HALT_OP(HOP)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check_output(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs, input logic [2:0] rt);
      return {op, rd, rs, rt, 3'b000};
   endfunction

   function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs, input logic [5:0] imm);
      return {op, rd, rs, imm};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = 16'd0;
      m_squash = 0;
      m_halt   = 0;
      m_ex     = '0;
   endtask

   function automatic logic [15:0] m_read(input logic [2:0] r, input logic wen,
                                          input logic [2:0] wrd, input logic [15:0] wdata);
      if (r == 3'd0) return 16'd0;
      if (wen && wrd == r) return wdata;
      return m_reg[r];
   endfunction

   task automatic model_eval(input logic [15:0] instr, input logic [15:0] addr,
                             input logic wen, input logic [2:0] wrd, input logic [15:0] wdata,
                             input logic br, input logic stall);
      int         opi;
      logic [2:0] rd, rs, rt;
      logic [2:0] srcs[$];
      bit         hazard;
      opi = int'(instr[15:12]);
      rd  = instr[11:9];
      rs  = instr[8:6];
      rt  = instr[5:3];
      e_pcwr   = 1'b1;
      e_felw   = 1'b1;
      e_ctr    = 2'd0;
      e_jt     = 16'(int'(addr) + 2 * int'($signed(instr[11:0])));
      n_ex     = m_ex;
      n_squash = m_squash;
      n_halt   = m_halt;
      srcs = {};
      if (opi inside {[1:8]}) srcs.push_back(rs);
      if (opi inside {[1:4]}) srcs.push_back(rt);
      if (opi inside {7, 8})  srcs.push_back(rd);
      hazard = 0;
      if (m_ex.valid && m_ex.mem_rd && m_ex.rd != 3'd0)
         foreach (srcs[i]) if (srcs[i] == m_ex.rd) hazard = 1;
      if (stall) begin
         e_pcwr = 1'b0;
         e_felw = 1'b0;
      end else if (m_halt) begin
         e_pcwr = 1'b0;
         e_felw = 1'b0;
         n_ex   = '0;
      end else if (m_squash > 0) begin
         n_ex     = '0;
         n_squash = br ? FS - 1 : m_squash - 1;
      end else if (br) begin
         n_ex     = '0;
         n_squash = FS - 1;
      end else if (hazard) begin
         e_pcwr = 1'b0;
         e_felw = 1'b0;
         n_ex   = '0;
      end else if (opi == 9) begin
         e_ctr    = 2'd2;
         n_ex     = '0;
         n_squash = FS;
      end else if (instr[15:12] == HOP) begin
         e_pcwr = 1'b0;
         e_felw = 1'b0;
         n_ex   = '0;
         n_halt = 1;
      end else begin
         n_ex.valid  = 1'b1;
         n_ex.op     = (opi <= 8) ? instr[15:12] : 4'd0;
         n_ex.reg_wr = opi inside {[1:6]};
         n_ex.mem_rd = (opi == 6);
         n_ex.mem_wr = (opi == 7);
         n_ex.rd     = rd;
         n_ex.a      = m_read(rs, wen, wrd, wdata);
         n_ex.b      = (opi inside {[1:4]}) ? m_read(rt, wen, wrd, wdata)
                                            : m_read(rd, wen, wrd, wdata);
         n_ex.imm    = 16'(int'($signed(instr[5:0])));
         n_ex.pc     = addr;
      end
   endtask

   // One clock: drive after the falling edge, check fetch controls, then the ID/EX latch.
   task automatic apply_stimulus(input logic [15:0] instr, input logic [15:0] addr,
                                 input logic wen, input logic [2:0] wrd,
                                 input logic [15:0] wdata, input logic br, input logic stall);
      @(negedge CLOCK_50);
      bus.id_instr        = instr;
      bus.id_instr_addr   = addr;
      bus.wb_wr_en        = wen;
      bus.wb_rd           = wrd;
      bus.wb_data         = wdata;
      bus.ex_branch_taken = br;
      bus.ex_stall        = stall;
      #1;
      model_eval(instr, addr, wen, wrd, wdata, br, stall);
      obs_pcwr = bus.PC_WR_EN;
      obs_felw = bus.FE_LATCH_WR;
      obs_ctr  = bus.ctr_sig;
      obs_jt   = bus.jump_target;
      check_output("pc_wr_en", 16'(obs_pcwr), 16'(e_pcwr));
      check_output("fe_latch_wr", 16'(obs_felw), 16'(e_felw));
      check_output("ctr_sig", 16'(obs_ctr), 16'(e_ctr));
      if (e_ctr == 2'd2) check_output("jump_target", obs_jt, e_jt);
      @(posedge CLOCK_50);
      #1;
      if (wen && wrd != 3'd0) m_reg[wrd] = wdata;
      m_ex     = n_ex;
      m_squash = n_squash;
      m_halt   = n_halt;
      check_output("ex_ctrl", 16'({bus.ex_valid, bus.ex_reg_wr, bus.ex_mem_rd, bus.ex_mem_wr}),
                   16'({m_ex.valid, m_ex.reg_wr, m_ex.mem_rd, m_ex.mem_wr}));
      check_output("ex_op", 16'(bus.ex_op), 16'(m_ex.op));
      check_output("ex_rd", 16'(bus.ex_rd), 16'(m_ex.rd));
      check_output("ex_a", bus.ex_a, m_ex.a);
      check_output("ex_b", bus.ex_b, m_ex.b);
      check_output("ex_imm", bus.ex_imm, m_ex.imm);
      check_output("ex_pc", bus.ex_pc, m_ex.pc);
      check_output("halted", 16'(bus.halted), 16'(m_halt));
   endtask

   initial begin
      logic [15:0] instr;
      logic [15:0] pc;
      bit          hold;

      reset               = 1'b1;
      bus.id_instr        = {HOP, 12'h000};
      bus.id_instr_addr   = 16'd0;
      bus.wb_wr_en        = 1'b0;
      bus.wb_rd           = 3'd0;
      bus.wb_data         = 16'd0;
      bus.ex_branch_taken = 1'b0;
      bus.ex_stall        = 1'b0;
      model_reset();
      #3;
      check_output("rst_pc_wr_en", 16'(bus.PC_WR_EN), 16'd1);
      check_output("rst_fe_latch_wr", 16'(bus.FE_LATCH_WR), 16'd1);
      check_output("rst_ctr_sig", 16'(bus.ctr_sig), 16'd0);
      check_output("rst_ex_valid", 16'(bus.ex_valid), 16'd0);
      check_output("rst_halted", 16'(bus.halted), 16'd0);
      bus.id_instr = 16'h0000;
      @(posedge CLOCK_50);
      #1;
      reset = 1'b0;

      $display("[TB] T1 register file write and ALU issue");
      apply_stimulus(16'h0000, 16'h0002, 1'b1, 3'd1, 16'd5, 1'b0, 1'b0);
      apply_stimulus(16'h0000, 16'h0004, 1'b1, 3'd2, 16'd7, 1'b0, 1'b0);
      apply_stimulus(enc_r(4'd1, 3'd3, 3'd1, 3'd2), 16'h0006, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      check_output("t1_ex_a", bus.ex_a, 16'd5);
      check_output("t1_ex_b", bus.ex_b, 16'd7);
      check_output("t1_ex_rd", 16'(bus.ex_rd), 16'd3);
      check_output("t1_ex_reg_wr", 16'(bus.ex_reg_wr), 16'd1);
      check_output("t1_ex_valid", 16'(bus.ex_valid), 16'd1);

      $display("[TB] T2 load-use interlock");
      apply_stimulus(enc_i(4'd6, 3'd1, 3'd2, 6'd0), 16'h0008, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      apply_stimulus(enc_r(4'd1, 3'd3, 3'd1, 3'd4), 16'h000A, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      check_output("t2_stall_pc_wr_en", 16'(obs_pcwr), 16'd0);
      check_output("t2_stall_fe_latch_wr", 16'(obs_felw), 16'd0);
      check_output("t2_stall_ex_valid", 16'(bus.ex_valid), 16'd0);
      apply_stimulus(enc_r(4'd1, 3'd3, 3'd1, 3'd4), 16'h000A, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      check_output("t2_retry_pc_wr_en", 16'(obs_pcwr), 16'd1);
      check_output("t2_retry_ex_valid", 16'(bus.ex_valid), 16'd1);
      apply_stimulus(enc_i(4'd6, 3'd0, 3'd2, 6'd0), 16'h000C, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      apply_stimulus(enc_r(4'd1, 3'd3, 3'd0, 3'd4), 16'h000E, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      check_output("t2_r0_no_stall", 16'(obs_pcwr), 16'd1);
      check_output("t2_r0_ex_valid", 16'(bus.ex_valid), 16'd1);

      $display("[TB] T3 JMP redirect and squash");
      apply_stimulus({4'd9, 12'hFFE}, 16'h0010, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      check_output("t3_ctr_sig", 16'(obs_ctr), 16'd2);
      check_output("t3_jump_target", obs_jt, 16'h000C);
      check_output("t3_jmp_bubble", 16'(bus.ex_valid), 16'd0);
      apply_stimulus(enc_r(4'd1, 3'd5, 3'd1, 3'd2), 16'h0012, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      check_output("t3_squash1", 16'(bus.ex_valid), 16'd0);
      apply_stimulus(enc_r(4'd1, 3'd5, 3'd1, 3'd2), 16'h000C, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      check_output("t3_squash2", 16'(bus.ex_valid), 16'd0);
      apply_stimulus(enc_r(4'd1, 3'd5, 3'd1, 3'd2), 16'h000E, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      check_output("t3_resume", 16'(bus.ex_valid), 16'd1);

      $display("[TB] T4 writeback bypass and r0");
      apply_stimulus(enc_r(4'd1, 3'd1, 3'd2, 3'd0), 16'h0010, 1'b1, 3'd2, 16'hBEEF, 1'b0, 1'b0);
      check_output("t4_bypass_a", bus.ex_a, 16'hBEEF);
      check_output("t4_r0_b", bus.ex_b, 16'd0);
      apply_stimulus(16'h0000, 16'h0012, 1'b1, 3'd0, 16'h1234, 1'b0, 1'b0);
      apply_stimulus(enc_r(4'd1, 3'd1, 3'd0, 3'd2), 16'h0014, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      check_output("t4_r0_reads_0", bus.ex_a, 16'd0);
      check_output("t4_stored_b", bus.ex_b, 16'hBEEF);

      $display("[TB] T5 branch beats load-use");
      apply_stimulus(enc_i(4'd6, 3'd1, 3'd2, 6'd0), 16'h0016, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      apply_stimulus(enc_r(4'd1, 3'd3, 3'd1, 3'd4), 16'h0018, 1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
      check_output("t5_no_stall", 16'(obs_pcwr), 16'd1);
      check_output("t5_bubble", 16'(bus.ex_valid), 16'd0);
      apply_stimulus(enc_r(4'd1, 3'd3, 3'd1, 3'd4), 16'h0040, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      check_output("t5_extra_squash", 16'(bus.ex_valid), 16'd0);
      apply_stimulus(enc_r(4'd1, 3'd3, 3'd1, 3'd4), 16'h0042, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      check_output("t5_resume", 16'(bus.ex_valid), 16'd1);

      $display("[TB] random phase");
      pc   = 16'h0100;
      hold = 0;
      instr = 16'h0000;
      for (int n = 0; n < 400; n++) begin
         if (!hold) begin
            instr = {4'($urandom_range(0, 14)), 3'($urandom_range(0, 3)),
                     3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom)};
            pc = pc + 16'd2;
         end
         apply_stimulus(instr, pc, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                        16'($urandom), 1'($urandom_range(0, 9) == 0),
                        1'($urandom_range(0, 9) == 0));
         hold = !e_felw;
      end
      for (int n = 0; n < 3; n++)
         apply_stimulus(16'h0000, 16'h0200, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

      $display("[TB] T6 HALT and async reset");
      apply_stimulus({HOP, 12'h000}, 16'h0202, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      check_output("t6_halt_pc_wr_en", 16'(obs_pcwr), 16'd0);
      check_output("t6_halted", 16'(bus.halted), 16'd1);
      for (int n = 0; n < 10; n++) begin
         apply_stimulus(enc_r(4'd1, 3'd1, 3'd2, 3'd3), 16'h0204, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
         check_output("t6_hold_pc_wr_en", 16'(obs_pcwr), 16'd0);
         check_output("t6_hold_halted", 16'(bus.halted), 16'd1);
      end
      #2;
      reset = 1'b1;
      #1;
      check_output("t6_async_halted", 16'(bus.halted), 16'd0);
      check_output("t6_async_ex_valid", 16'(bus.ex_valid), 16'd0);
      check_output("t6_async_pc_wr_en", 16'(bus.PC_WR_EN), 16'd1);
      @(posedge CLOCK_50);
      #1;
      reset = 1'b0;
      model_reset();
      apply_stimulus(enc_i(4'd5, 3'd2, 3'd0, 6'h3F), 16'h0300, 1'b1, 3'd4, 16'h00AA, 1'b0, 1'b0);
      check_output("t6_issue_valid", 16'(bus.ex_valid), 16'd1);
      #2;
      reset = 1'b1;
      #1;
      check_output("t6_async_clear_valid", 16'(bus.ex_valid), 16'd0);
      check_output("t6_async_clear_pc", bus.ex_pc, 16'd0);
      check_output("t6_async_clear_op", 16'(bus.ex_op), 16'd0);
      @(posedge CLOCK_50);
      #1;
      reset = 1'b0;
      model_reset();
      apply_stimulus(enc_r(4'd2, 3'd5, 3'd4, 3'd0), 16'h0302, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      apply_stimulus(enc_r(4'd3, 3'd5, 3'd1, 3'd2), 16'h0304, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
